// File: rtl/wave_sequencer.sv
// wave_sequencer: phase-accumulator address generator and sample mux
// for the four waveform ROMs; config changes land only on a phase wrap.
module wave_sequencer #(
    parameter int                 PHASE_W  = 24,
    parameter logic [PHASE_W-1:0] DEF_FREQ = 24'h010000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [1:0]         i_cfg_wave,
    input  logic [PHASE_W-1:0] i_cfg_freq,
    output logic [3:0]         o_rom_en,
    output logic [7:0]         o_rom_addr,
    input  logic [9:0]         i_rom_q0,
    input  logic [9:0]         i_rom_q1,
    input  logic [9:0]         i_rom_q2,
    input  logic [9:0]         i_rom_q3,
    output logic [9:0]         o_wave_out,
    output logic               o_wave_valid,
    output logic               o_cycle_done,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_freq;
    logic [PHASE_W-1:0] r_pend_freq;
    logic [1:0]         r_wave;
    logic [1:0]         r_pend_wave;
    logic               r_pend;
    logic [1:0]         r_wave_d;
    logic               r_en_d;
    logic [9:0]         r_wave_out;
    logic               r_wave_valid;
    logic               r_cycle_done;

    logic [PHASE_W:0]   w_sum;
    logic               w_wrap;
    logic               w_accept;
    logic [9:0]         w_sel;

    assign w_sum    = {1'b0, r_phase} + {1'b0, r_freq};
    assign w_wrap   = w_sum[PHASE_W];
    assign w_accept = i_cfg_valid && o_cfg_ready;

    assign o_cfg_ready  = !r_pend;
    assign o_busy       = (r_state != S_IDLE);
    assign o_rom_addr   = r_phase[PHASE_W-1 -: 8];
    assign o_rom_en     = (r_state == S_IDLE) ? 4'b0000
                                              : (4'b0001 << r_wave);
    assign o_wave_out   = r_wave_out;
    assign o_wave_valid = r_wave_valid;
    assign o_cycle_done = r_cycle_done;

    // Control FSM: accumulator, config staging and stop handling.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_freq       <= DEF_FREQ;
            r_wave       <= 2'd0;
            r_pend_freq  <= '0;
            r_pend_wave  <= 2'd0;
            r_pend       <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    if (w_accept) begin
                        r_freq <= i_cfg_freq;
                        r_wave <= i_cfg_wave;
                    end
                    if (i_run)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_wrap) begin
                        r_cycle_done <= 1'b1;
                        // A config seen on the wrap clk is already at a
                        // period boundary, so it is applied directly.
                        if (r_pend) begin
                            r_freq <= r_pend_freq;
                            r_wave <= r_pend_wave;
                            r_pend <= 1'b0;
                        end else if (w_accept) begin
                            r_freq <= i_cfg_freq;
                            r_wave <= i_cfg_wave;
                        end
                        if (r_pend || !i_run)
                            r_phase <= '0;
                        else
                            r_phase <= w_sum[PHASE_W-1:0];
                        if (!i_run)
                            r_state <= S_DRAIN;
                    end else begin
                        r_phase <= w_sum[PHASE_W-1:0];
                        if (w_accept) begin
                            r_pend_freq <= i_cfg_freq;
                            r_pend_wave <= i_cfg_wave;
                            r_pend      <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_phase <= '0;
                    if (w_accept) begin
                        r_freq <= i_cfg_freq;
                        r_wave <= i_cfg_wave;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pick the ROM selected by the wave code aligned to ROM latency.
    always_comb begin
        w_sel = '0;
        unique case (r_wave_d)
            2'd0: w_sel = i_rom_q0;
            2'd1: w_sel = i_rom_q1;
            2'd2: w_sel = i_rom_q2;
            2'd3: w_sel = i_rom_q3;
            default: w_sel = '0;
        endcase
    end

    // Output pipeline: delay enable/wave by the ROM latency, then register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wave_d     <= 2'd0;
            r_en_d       <= 1'b0;
            r_wave_out   <= '0;
            r_wave_valid <= 1'b0;
        end else begin
            r_wave_d     <= r_wave;
            r_en_d       <= (r_state != S_IDLE);
            r_wave_valid <= r_en_d;
            r_wave_out   <= r_en_d ? w_sel : 10'd0;
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed vectors plus hand-written period sequences
// with behavioural ROM models for the four waveforms.
module tb_wave_sequencer;

    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_wave;
    logic [PW-1:0] cfg_freq;
    logic [3:0]    rom_en;
    logic [7:0]    rom_addr;
    logic [9:0]    q0 = '0;
    logic [9:0]    q1 = '0;
    logic [9:0]    q2 = '0;
    logic [9:0]    q3 = '0;
    logic [9:0]    wave_out;
    logic          wave_valid;
    logic          cycle_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wave_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_run       (run),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_wave  (cfg_wave),
        .i_cfg_freq  (cfg_freq),
        .o_rom_en    (rom_en),
        .o_rom_addr  (rom_addr),
        .i_rom_q0    (q0),
        .i_rom_q1    (q1),
        .i_rom_q2    (q2),
        .i_rom_q3    (q3),
        .o_wave_out  (wave_out),
        .o_wave_valid(wave_valid),
        .o_cycle_done(cycle_done),
        .o_busy      (busy)
    );

    function automatic logic [9:0] rom_f(input int w, input int a);
        logic [7:0] ad;
        ad = a[7:0];
        case (w)
            0:       return (ad < 8'd128) ? {ad[6:0], 3'b000} : 10'd0;
            1:       return {~ad, 2'b01};
            2:       return ad[7] ? 10'h3FF : 10'h001;
            default: return {ad, 2'b10};
        endcase
    endfunction

    // ROM models: one clk of read latency
    always @(posedge clk) begin
        q0 <= rom_f(0, int'(rom_addr));
        q1 <= rom_f(1, int'(rom_addr));
        q2 <= rom_f(2, int'(rom_addr));
        q3 <= rom_f(3, int'(rom_addr));
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst_n;
        logic          run;
        logic          cv;
        logic [1:0]    cw;
        logic [PW-1:0] cf;
        logic [7:0]    addr;
        logic [3:0]    en;
        logic [9:0]    out;
        logic          vld;
        logic          done;
        logic          rdy;
        logic          bsy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // rst run cv cw cf | addr en out vld done rdy busy
        tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h0,
                   8'd0, 4'b0000, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2'd3, 24'h050000,
                   8'd0, 4'b0000, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h0,
                   8'd0, 4'b0001, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h0,
                   8'd1, 4'b0001, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h0,
                   8'd2, 4'b0001, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h0,
                   8'd3, 4'b0001, 10'd8, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h0,
                   8'd4, 4'b0001, 10'd16, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h0,
                   8'd5, 4'b0001, 10'd24, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0;
        cfg_wave = 2'd0; cfg_freq = '0;

        // reset and start-up vectors
        for (int i = 0; i < 8; i++) begin
            rst_n = tbl[i].rst_n; run = tbl[i].run;
            cfg_valid = tbl[i].cv; cfg_wave = tbl[i].cw;
            cfg_freq = tbl[i].cf;
            tick();
            chk($sformatf("v%0d addr", i), rom_addr, tbl[i].addr);
            chk($sformatf("v%0d en", i), rom_en, tbl[i].en);
            chk($sformatf("v%0d out", i), wave_out, tbl[i].out);
            chk($sformatf("v%0d vld", i), wave_valid, tbl[i].vld);
            chk($sformatf("v%0d done", i), cycle_done, tbl[i].done);
            chk($sformatf("v%0d rdy", i), cfg_ready, tbl[i].rdy);
            chk($sformatf("v%0d busy", i), busy, tbl[i].bsy);
        end
        cfg_valid = 1'b0;

        // default-frequency triangle ramp across one wrap
        for (int k = 6; k <= 300; k++) begin
            tick();
            chk($sformatf("ramp%0d addr", k), rom_addr, k % 256);
            chk($sformatf("ramp%0d done", k), cycle_done, (k % 256) == 0);
            chk($sformatf("ramp%0d out", k), wave_out, rom_f(0, (k - 2) % 256));
        end

        // config mid-period (addr 44), then a second offer while pending
        chk("cfg1 rdy before", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_wave = 2'd3; cfg_freq = 24'h020000;
        tick();
        chk("cfg1 rdy after", cfg_ready, 0);
        cfg_wave = 2'd2; cfg_freq = 24'h010000;
        for (int k = 302; k <= 511; k++) begin
            tick();
            chk($sformatf("pend%0d addr", k), rom_addr, k % 256);
            chk($sformatf("pend%0d rdy", k), cfg_ready, 0);
            chk($sformatf("pend%0d en", k), rom_en, 4'b0001);
            chk($sformatf("pend%0d out", k), wave_out, rom_f(0, (k - 2) % 256));
        end
        tick();
        chk("wrapA addr", rom_addr, 0);
        chk("wrapA done", cycle_done, 1);
        chk("wrapA en", rom_en, 4'b1000);
        chk("wrapA rdy", cfg_ready, 1);
        chk("wrapA out", wave_out, rom_f(0, 254));
        tick();
        chk("cfg2 rdy after", cfg_ready, 0);
        chk("cfg2 addr", rom_addr, 2);
        chk("cfg2 out", wave_out, rom_f(0, 255));
        cfg_valid = 1'b0;
        for (int j = 2; j <= 127; j++) begin
            tick();
            chk($sformatf("cos%0d addr", j), rom_addr, (2 * j) % 256);
            chk($sformatf("cos%0d done", j), cycle_done, 0);
            chk($sformatf("cos%0d en", j), rom_en, 4'b1000);
            chk($sformatf("cos%0d out", j), wave_out, rom_f(3, 2 * (j - 2)));
        end
        tick();
        chk("wrapB addr", rom_addr, 0);
        chk("wrapB done", cycle_done, 1);
        chk("wrapB en", rom_en, 4'b0100);
        chk("wrapB rdy", cfg_ready, 1);
        chk("wrapB out", wave_out, rom_f(3, 252));

        // square wave, stop requested at addr 37
        for (int m = 1; m <= 255; m++) begin
            tick();
            chk($sformatf("sq%0d addr", m), rom_addr, m);
            chk($sformatf("sq%0d busy", m), busy, 1);
            chk($sformatf("sq%0d en", m), rom_en, 4'b0100);
            chk($sformatf("sq%0d out", m), wave_out,
                (m == 1) ? rom_f(3, 254) : rom_f(2, m - 2));
            if (m == 37) run = 1'b0;
        end
        tick();
        chk("drain addr", rom_addr, 0);
        chk("drain done", cycle_done, 1);
        chk("drain busy", busy, 1);
        chk("drain en", rom_en, 4'b0100);
        chk("drain out", wave_out, rom_f(2, 254));
        tick();
        chk("idle busy", busy, 0);
        chk("idle en", rom_en, 4'b0000);
        chk("idle done", cycle_done, 0);
        chk("idle vld", wave_valid, 1);
        chk("idle out", wave_out, rom_f(2, 255));
        tick();
        chk("last vld", wave_valid, 1);
        chk("last out", wave_out, rom_f(2, 0));
        tick();
        chk("post vld", wave_valid, 0);
        chk("post out", wave_out, 0);

        // freq = 0: frozen phase, stuck pending config, stop ignored
        cfg_valid = 1'b1; cfg_wave = 2'd1; cfg_freq = 24'h0;
        tick();
        chk("f0 idle rdy", cfg_ready, 1);
        chk("f0 idle busy", busy, 0);
        cfg_valid = 1'b0; run = 1'b1;
        tick();
        chk("f0 busy", busy, 1);
        chk("f0 en", rom_en, 4'b0010);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("f0 %0d addr", i), rom_addr, 0);
            chk($sformatf("f0 %0d done", i), cycle_done, 0);
            if (i >= 2)
                chk($sformatf("f0 %0d out", i), wave_out, rom_f(1, 0));
        end
        cfg_valid = 1'b1; cfg_wave = 2'd3; cfg_freq = 24'h010000;
        tick();
        chk("f0 pend rdy", cfg_ready, 0);
        cfg_valid = 1'b0; run = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("f0s %0d addr", i), rom_addr, 0);
            chk($sformatf("f0s %0d done", i), cycle_done, 0);
            chk($sformatf("f0s %0d en", i), rom_en, 4'b0010);
            chk($sformatf("f0s %0d busy", i), busy, 1);
        end
        rst_n = 1'b0;
        tick();
        chk("f0 rst addr", rom_addr, 0);
        chk("f0 rst en", rom_en, 0);
        chk("f0 rst out", wave_out, 0);
        chk("f0 rst vld", wave_valid, 0);
        chk("f0 rst done", cycle_done, 0);
        chk("f0 rst rdy", cfg_ready, 1);
        chk("f0 rst busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("f0 rel busy", busy, 0);

        // config with run in the same IDLE clk, then reset at addr 100
        cfg_valid = 1'b1; cfg_wave = 2'd2; cfg_freq = 24'h040000; run = 1'b1;
        tick();
        chk("mr start busy", busy, 1);
        chk("mr start en", rom_en, 4'b0100);
        chk("mr start addr", rom_addr, 0);
        cfg_valid = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk($sformatf("mr%0d addr", k), rom_addr, (4 * k) % 256);
        end
        rst_n = 1'b0;
        tick();
        chk("mr rst addr", rom_addr, 0);
        chk("mr rst en", rom_en, 0);
        chk("mr rst busy", busy, 0);
        chk("mr rst out", wave_out, 0);
        chk("mr rst vld", wave_valid, 0);
        chk("mr rst done", cycle_done, 0);
        chk("mr rst rdy", cfg_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("mr re busy", busy, 1);
        chk("mr re en", rom_en, 4'b0001);
        chk("mr re addr0", rom_addr, 0);
        tick();
        chk("mr re addr1", rom_addr, 1);
        tick();
        chk("mr re addr2", rom_addr, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
